// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divide controller slice: operand width, divider
// iteration count, operation and FSM state encodings, and a conditional
// two's-complement negation helper used for magnitude and sign fix-up.
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
      return n ? ('0 - v) : v;
   endfunction

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
// Request/response bundle of the divide controller.
//   start  : request, sampled only while the controller is IDLE or DONE
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1    : dividend, sampled with start
//   rs2    : divisor, sampled with start
//   kill   : abort of the in-flight operation
//   busy   : high while the core is loading/running
//   done   : one-cycle pulse, result valid
//   result : quotient or remainder, held until the next done
// master drives requests, slave (the controller) drives responses.
// -----------------------------------------------------------------------------
interface div_if;
   import div_pkg::*;

   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, rs1, rs2, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, op, rs1, rs2, kill,
      output busy, done, result
   );

endinterface

// File: rtl/alu_div.sv
// -----------------------------------------------------------------------------
// alu_div
// Unsigned restoring divider, one quotient bit per clock.
//   clk       : clock, rising edge
//   rst       : synchronous load; captures dividend/divisor and clears state
//   dividend  : unsigned dividend, captured while rst=1
//   divisor   : unsigned divisor, captured while rst=1
//   quotient  : quotient, valid while ready=1
//   remainder : remainder, valid while ready=1
//   ready     : high once CYCLES iterations have completed after a load
// -----------------------------------------------------------------------------
module alu_div #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            ready
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [XLEN-1:0] r_q;
   logic [XLEN-1:0] r_r;
   logic [XLEN-1:0] r_d;
   logic [CW-1:0]   r_cnt;

   logic [XLEN:0]   w_cand;
   logic            w_fits;
   logic [XLEN-1:0] w_diff;

   // Shifted partial remainder can reach XLEN+1 bits; when it fits, the
   // difference is below the divisor, so the low XLEN bits are exact.
   always_comb begin
      w_cand = {r_r, r_q[XLEN-1]};
      w_fits = (w_cand >= {1'b0, r_d});
      w_diff = w_cand[XLEN-1:0] - r_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= dividend;
         r_r   <= '0;
         r_d   <= divisor;
         r_cnt <= '0;
      end else if (!ready) begin
         r_q   <= {r_q[XLEN-2:0], w_fits};
         r_r   <= w_fits ? w_diff : w_cand[XLEN-1:0];
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign ready     = (r_cnt == CW'(CYCLES));
   assign quotient  = r_q;
   assign remainder = r_r;

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Signed/unsigned divide and remainder controller around one unsigned
// restoring divider core (alu_div).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_if.slave -- start/op/rs1/rs2/kill in, busy/done/result out
// Normal operations take IDLE->LOAD->RUN->DONE (done 35 cycles after the
// start cycle). Divide-by-zero and signed overflow skip the core and reach
// DONE on the next edge.
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter int unsigned XLEN = div_pkg::XLEN
) (
   input logic   clk,
   input logic   rst_n,
   div_if.slave  bus
);
   import div_pkg::*;

   state_e          r_state;
   op_e             r_op;
   logic            r_neg_a;
   logic            r_neg_b;
   logic [XLEN-1:0] r_mag_a;
   logic [XLEN-1:0] r_mag_b;
   logic [XLEN-1:0] r_result;
   logic            r_load;
   logic            r_busy;
   logic            r_done;

   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   logic            w_ready;

   op_e             w_op;
   logic            w_signed;
   logic            w_is_rem;
   logic            w_rs1_neg;
   logic            w_rs2_neg;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN-1:0] w_bypass;
   logic [XLEN-1:0] w_fixed;

   always_comb begin
      w_op      = op_e'(bus.op);
      w_signed  = (w_op == OP_DIV) || (w_op == OP_REM);
      w_is_rem  = (w_op == OP_REM) || (w_op == OP_REMU);
      w_rs1_neg = w_signed & bus.rs1[XLEN-1];
      w_rs2_neg = w_signed & bus.rs2[XLEN-1];
      w_div0    = (bus.rs2 == '0);
      w_ovf     = w_signed && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
      if (w_div0)
         w_bypass = w_is_rem ? bus.rs1 : '1;
      else
         w_bypass = w_is_rem ? '0 : bus.rs1;
   end

   // Sign flags are only set for signed ops, so unsigned results pass through.
   always_comb begin
      if ((r_op == OP_REM) || (r_op == OP_REMU))
         w_fixed = neg_if(r_neg_a, w_rem);
      else
         w_fixed = neg_if(r_neg_a ^ r_neg_b, w_quo);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= OP_DIV;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_result <= '0;
         r_load   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_load <= 1'b0;
         r_done <= 1'b0;
         if (bus.kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     r_op    <= w_op;
                     r_neg_a <= w_rs1_neg;
                     r_neg_b <= w_rs2_neg;
                     r_mag_a <= neg_if(w_rs1_neg, bus.rs1);
                     r_mag_b <= neg_if(w_rs2_neg, bus.rs2);
                     if (w_div0 || w_ovf) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_bypass;
                        r_busy   <= 1'b0;
                     end else begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                     end
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               S_LOAD: begin
                  r_state <= S_RUN;
               end
               S_RUN: begin
                  if (w_ready) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_result <= w_fixed;
                     r_busy   <= 1'b0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   alu_div #(
      .XLEN   (XLEN),
      .CYCLES (DIV_CYCLES)
   ) u_core (
      .clk       (clk),
      .rst       (r_load),
      .dividend  (r_mag_a),
      .divisor   (r_mag_b),
      .quotient  (w_quo),
      .remainder (w_rem),
      .ready     (w_ready)
   );

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule
